// File: rtl/ro_puf_if.sv
// ro_puf_if: start/busy/done handshake and result bus of the ring-oscillator PUF engine.
// master = requester side (drives enable/challenge), slave = engine side.
interface ro_puf_if #(
  parameter int RESP_BITS = 4,
  parameter int SEL_W     = 3,
  parameter int CNT_W     = 8
);
  logic                          enable;
  logic [RESP_BITS*2*SEL_W-1:0]  challenge;
  logic                          busy;
  logic                          done;
  logic [RESP_BITS-1:0]          response;
  logic [CNT_W-1:0]              count_a;
  logic [CNT_W-1:0]              count_b;
  logic [RESP_BITS-1:0]          stable_mask;

  modport master (
    output enable, challenge,
    input  busy, done, response, count_a, count_b, stable_mask
  );

  modport slave (
    input  enable, challenge,
    output busy, done, response, count_a, count_b, stable_mask
  );
endinterface

// File: rtl/ro_puf_engine.sv
// ro_puf_engine: ring-oscillator PUF. For each of RESP_BITS oscillator pairs in the
// latched challenge, counts rising edges of both selected oscillators over MEAS_CYC
// clocks (saturating) and sets response bit i when count_a > count_b (ties give 0).
// Optional feature macro RO_PUF_MARGIN_EN: per-bit stability flag |a-b| >= MARGIN;
// without it stable_mask is simply driven all-ones after the first compare.
module ro_puf_engine #(
  parameter int N_RO      = 8,
  parameter int SEL_W     = 3,
  parameter int CNT_W     = 8,
  parameter int MEAS_CYC  = 256,
  parameter int RESP_BITS = 4
`ifdef RO_PUF_MARGIN_EN
  ,
  parameter int MARGIN    = 4
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_RO-1:0]  ro_in,
  ro_puf_if.slave          bus
);

  localparam int CH_W  = RESP_BITS * 2 * SEL_W;
  localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int WIN_W = $clog2(MEAS_CYC);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(MEAS_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RESP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_MEASURE = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CH_W-1:0]      chal_q, chal_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [WIN_W-1:0]     win_q, win_d;
  logic [CNT_W-1:0]     cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0]     cnt_b_q, cnt_b_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [RESP_BITS-1:0] response_q, response_d;
  logic [CNT_W-1:0]     count_a_q, count_a_d;
  logic [CNT_W-1:0]     count_b_q, count_b_d;
  logic [RESP_BITS-1:0] stable_q, stable_d;
  logic [N_RO-1:0]      sync1_q, sync1_d;
  logic [N_RO-1:0]      sync2_q, sync2_d;
  logic [N_RO-1:0]      hist_q, hist_d;

  logic [N_RO-1:0]      rise_s;
  logic [2*SEL_W-1:0]   pair_s;
  logic [SEL_W-1:0]     sel_a_s;
  logic [SEL_W-1:0]     sel_b_s;
  logic                 rise_a_s;
  logic                 rise_b_s;

`ifdef RO_PUF_MARGIN_EN
  localparam logic [CNT_W:0] MARGIN_V = (CNT_W + 1)'(MARGIN);
  logic [CNT_W:0] diff_s;

  // Unsigned absolute count difference, one bit wider than the counters.
  always_comb begin
    diff_s = '0;
    if (cnt_a_q >= cnt_b_q) begin
      diff_s = {1'b0, cnt_a_q} - {1'b0, cnt_b_q};
    end else begin
      diff_s = {1'b0, cnt_b_q} - {1'b0, cnt_a_q};
    end
  end
`endif

  // Select the oscillator pair under evaluation and its synchronised rising edges.
  always_comb begin
    rise_s   = sync2_q & ~hist_q;
    pair_s   = chal_q[idx_q * (2 * SEL_W) +: 2 * SEL_W];
    sel_a_s  = pair_s[2*SEL_W-1:SEL_W];
    sel_b_s  = pair_s[SEL_W-1:0];
    rise_a_s = rise_s[sel_a_s];
    rise_b_s = rise_s[sel_b_s];
  end

  // Next-state and datapath: synchroniser shift, FSM sequencing, counting, compare.
  always_comb begin
    state_d    = state_q;
    chal_d     = chal_q;
    idx_d      = idx_q;
    win_d      = win_q;
    cnt_a_d    = cnt_a_q;
    cnt_b_d    = cnt_b_q;
    response_d = response_q;
    count_a_d  = count_a_q;
    count_b_d  = count_b_q;
    stable_d   = stable_q;
    sync1_d    = ro_in;
    sync2_d    = sync1_q;
    hist_d     = sync2_q;

    case (state_q)
      S_IDLE: begin
        if (bus.enable) begin
          chal_d     = bus.challenge;
          response_d = '0;
          stable_d   = '0;
          idx_d      = '0;
          state_d    = S_CLEAR;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_CLEAR: begin
        cnt_a_d = '0;
        cnt_b_d = '0;
        win_d   = '0;
        state_d = S_MEASURE;
      end
      S_MEASURE: begin
        // Counters stick at all-ones rather than wrapping.
        if (rise_a_s && (cnt_a_q != CNT_MAX)) begin
          cnt_a_d = cnt_a_q + 1'b1;
        end else begin
          cnt_a_d = cnt_a_q;
        end
        if (rise_b_s && (cnt_b_q != CNT_MAX)) begin
          cnt_b_d = cnt_b_q + 1'b1;
        end else begin
          cnt_b_d = cnt_b_q;
        end
        if (win_q == WIN_LAST) begin
          state_d = S_COMPARE;
        end else begin
          win_d   = win_q + 1'b1;
        end
      end
      S_COMPARE: begin
        response_d[idx_q] = (cnt_a_q > cnt_b_q);
        count_a_d         = cnt_a_q;
        count_b_d         = cnt_b_q;
`ifdef RO_PUF_MARGIN_EN
        stable_d[idx_q]   = (sel_a_s != sel_b_s) && (diff_s >= MARGIN_V);
`else
        stable_d          = {RESP_BITS{1'b1}};
`endif
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_CLEAR;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // busy follows the next state so it falls exactly as IDLE is re-entered;
    // done is the registered image of the DONE state, a single-cycle pulse.
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_DONE);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      chal_q     <= '0;
      idx_q      <= '0;
      win_q      <= '0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      response_q <= '0;
      count_a_q  <= '0;
      count_b_q  <= '0;
      stable_q   <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      hist_q     <= '0;
    end else begin
      state_q    <= state_d;
      chal_q     <= chal_d;
      idx_q      <= idx_d;
      win_q      <= win_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      response_q <= response_d;
      count_a_q  <= count_a_d;
      count_b_q  <= count_b_d;
      stable_q   <= stable_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      hist_q     <= hist_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.response    = response_q;
  assign bus.count_a     = count_a_q;
  assign bus.count_b     = count_b_q;
  assign bus.stable_mask = stable_q;

endmodule

// File: tb/tb_ro_puf_engine.sv
// tb_ro_puf_engine: directed table-driven bench for ro_puf_engine (MEAS_CYC=64),
// plus a CNT_W=4 instance for counter saturation and hand-written handshake/reset cases.
module tb_ro_puf_engine;

  logic       clk;
  logic       reset;
  logic [7:0] ro_main;
  logic [7:0] ro_sat;
  int         ph;
  int         n_cmp;
  int         n_bad;

  ro_puf_if #(.RESP_BITS(4), .SEL_W(3), .CNT_W(8)) bus_m ();
  ro_puf_if #(.RESP_BITS(4), .SEL_W(3), .CNT_W(4)) bus_s ();

  ro_puf_engine #(.N_RO(8), .SEL_W(3), .CNT_W(8), .MEAS_CYC(64), .RESP_BITS(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .ro_in (ro_main),
    .bus   (bus_m)
  );

  ro_puf_engine #(.N_RO(8), .SEL_W(3), .CNT_W(4), .MEAS_CYC(64), .RESP_BITS(4)) u_sat (
    .clk   (clk),
    .reset (reset),
    .ro_in (ro_sat),
    .bus   (bus_s)
  );

  typedef struct {
    logic [23:0] chal;
    logic [3:0]  resp;
    logic [7:0]  a_lo, a_hi, b_lo, b_hi;
    logic [3:0]  stab_m;
  } vec_t;

  vec_t vecs [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oscillator models: ro_main periods 4,6,8,16 clk on bits 0..3, others idle;
  // ro_sat period 2 on bit 0 and period 4 on bit 1.
  always @(negedge clk) begin
    ph = ph + 1;
    ro_main[0] = ((ph % 4) < 2);
    ro_main[1] = ((ph % 6) < 3);
    ro_main[2] = ((ph % 8) < 4);
    ro_main[3] = ((ph % 16) < 8);
    ro_main[7:4] = 4'h0;
    ro_sat[0] = ph[0];
    ro_sat[1] = ((ph % 4) < 2);
    ro_sat[7:2] = 6'h00;
  end

  function automatic logic [23:0] mkc(input logic [2:0] a0, b0, a1, b1, a2, b2, a3, b3);
    return {a3, b3, a2, b2, a1, b1, a0, b0};
  endfunction

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input logic [31:0] act, input logic [31:0] lo, input logic [31:0] hi);
    n_cmp++;
    if ((act < lo) || (act > hi) || $isunknown(act)) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Start a run on the main DUT, scramble the challenge after the latch, wait for done.
  task automatic run_main(input logic [23:0] chal, output int lat);
    @(negedge clk);
    bus_m.enable = 1'b1;
    bus_m.challenge = chal;
    @(posedge clk); #1;
    bus_m.enable = 1'b0;
    bus_m.challenge = ~chal;
    check_eq("busy_after_start", {31'd0, bus_m.busy}, 32'd1);
    lat = 0;
    while ((bus_m.done !== 1'b1) && (lat < 400)) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int ndone;
    logic [3:0] exp_stab;

    n_cmp = 0;
    n_bad = 0;
    ph = 0;
    ro_main = 8'h00;
    ro_sat = 8'h00;
    reset = 1'b1;
    bus_m.enable = 1'b0;
    bus_m.challenge = 24'h0;
    bus_s.enable = 1'b0;
    bus_s.challenge = 24'h0;

    vecs[0] = '{mkc(0,1, 1,0, 2,2, 2,3), 4'b1001, 8'd8,  8'd8,  8'd4,  8'd4,  4'b1011};
    vecs[1] = '{mkc(3,4, 4,3, 0,3, 2,0), 4'b0101, 8'd8,  8'd8,  8'd15, 8'd16, 4'b1111};
    vecs[2] = '{mkc(7,7, 1,3, 3,1, 1,0), 4'b0010, 8'd10, 8'd11, 8'd15, 8'd16, 4'b1110};
    vecs[3] = '{mkc(0,7, 7,0, 2,1, 6,5), 4'b0001, 8'd0,  8'd0,  8'd0,  8'd0,  4'b0011};

    // Reset state of both instances.
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", {31'd0, bus_m.busy}, 32'd0);
    check_eq("rst_done", {31'd0, bus_m.done}, 32'd0);
    check_eq("rst_resp", {28'd0, bus_m.response}, 32'd0);
    check_eq("rst_cnt", {16'd0, bus_m.count_a, bus_m.count_b}, 32'd0);
    check_eq("rst_stable", {28'd0, bus_m.stable_mask}, 32'd0);
    check_eq("rst_sat_all", {19'd0, bus_s.busy, bus_s.done, bus_s.response, bus_s.count_a, bus_s.count_b}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);

    // Table-driven runs: latency, response, last-pair counts, stability mask.
    for (int i = 0; i < 4; i++) begin
`ifdef RO_PUF_MARGIN_EN
      exp_stab = vecs[i].stab_m;
`else
      exp_stab = 4'hF;
`endif
      run_main(vecs[i].chal, lat);
      check_eq($sformatf("v%0d_latency", i), lat, 32'd265);
      check_eq($sformatf("v%0d_busy_at_done", i), {31'd0, bus_m.busy}, 32'd0);
      check_eq($sformatf("v%0d_response", i), {28'd0, bus_m.response}, {28'd0, vecs[i].resp});
      check_rng($sformatf("v%0d_count_a", i), {24'd0, bus_m.count_a}, {24'd0, vecs[i].a_lo}, {24'd0, vecs[i].a_hi});
      check_rng($sformatf("v%0d_count_b", i), {24'd0, bus_m.count_b}, {24'd0, vecs[i].b_lo}, {24'd0, vecs[i].b_hi});
      check_eq($sformatf("v%0d_stable", i), {28'd0, bus_m.stable_mask}, {28'd0, exp_stab});
      @(posedge clk); #1;
      check_eq($sformatf("v%0d_done_pulse", i), {31'd0, bus_m.done}, 32'd0);
      check_eq($sformatf("v%0d_resp_hold", i), {28'd0, bus_m.response}, {28'd0, vecs[i].resp});
      repeat (3) @(posedge clk);
    end

    // Saturation with 4-bit counters: both sides stick at 15, ties give 0.
    @(negedge clk);
    bus_s.enable = 1'b1;
    bus_s.challenge = mkc(0,1, 1,0, 0,0, 0,1);
    @(posedge clk); #1;
    bus_s.enable = 1'b0;
    lat = 0;
    while ((bus_s.done !== 1'b1) && (lat < 400)) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("sat_latency", lat, 32'd265);
    check_eq("sat_response", {28'd0, bus_s.response}, 32'd0);
    check_eq("sat_count_a", {28'd0, bus_s.count_a}, 32'd15);
    check_eq("sat_count_b", {28'd0, bus_s.count_b}, 32'd15);
`ifdef RO_PUF_MARGIN_EN
    check_eq("sat_stable", {28'd0, bus_s.stable_mask}, 32'd0);
`else
    check_eq("sat_stable", {28'd0, bus_s.stable_mask}, 32'hF);
`endif

    // enable pulsed while busy: ignored, exactly one done, original result.
    @(negedge clk);
    bus_m.enable = 1'b1;
    bus_m.challenge = vecs[0].chal;
    @(negedge clk);
    bus_m.enable = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    bus_m.enable = 1'b1;
    bus_m.challenge = vecs[2].chal;
    @(negedge clk);
    bus_m.enable = 1'b0;
    ndone = 0;
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      if (bus_m.done === 1'b1) ndone++;
    end
    check_eq("busy_enable_ndone", ndone, 32'd1);
    check_eq("busy_enable_resp", {28'd0, bus_m.response}, {28'd0, vecs[0].resp});

    // enable held high: back-to-back runs with a single IDLE cycle between.
    @(negedge clk);
    bus_m.enable = 1'b1;
    bus_m.challenge = vecs[1].chal;
    lat = 0;
    while ((bus_m.done !== 1'b1) && (lat < 400)) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("held_first_busy", {31'd0, bus_m.busy}, 32'd0);
    @(posedge clk); #1;
    check_eq("held_restart_busy", {31'd0, bus_m.busy}, 32'd1);
    lat = 0;
    while ((bus_m.done !== 1'b1) && (lat < 400)) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("held_second_latency", lat, 32'd265);
    @(negedge clk);
    bus_m.enable = 1'b0;
    @(posedge clk); #1;
    check_eq("held_stop_busy", {31'd0, bus_m.busy}, 32'd0);

    // Reset during MEASURE of pair 1: outputs clear at once, no done afterwards.
    @(negedge clk);
    bus_m.enable = 1'b1;
    bus_m.challenge = vecs[0].chal;
    @(posedge clk); #1;
    bus_m.enable = 1'b0;
    repeat (86) @(posedge clk);
    #1;
    check_rng("pre_reset_count_a", {24'd0, bus_m.count_a}, 32'd15, 32'd16);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_busy", {31'd0, bus_m.busy}, 32'd0);
    check_eq("mid_rst_resp", {28'd0, bus_m.response}, 32'd0);
    check_eq("mid_rst_counts", {16'd0, bus_m.count_a, bus_m.count_b}, 32'd0);
    check_eq("mid_rst_stable", {28'd0, bus_m.stable_mask}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (bus_m.done === 1'b1) ndone++;
    end
    check_eq("post_rst_ndone", ndone, 32'd0);
    check_eq("post_rst_busy", {31'd0, bus_m.busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
